corner_smoother: RTL and testbench

CORNER_SMOOTHER -- requirements
Module: corner_smoother

---
 rtl/corner_pkg.sv | 42 ++++
 rtl/corner_smoother_if.sv | 30 +++
 rtl/corner_iir_step.sv | 55 +++++
 rtl/corner_smoother.sv | 187 ++++++++++++++++++
 tb/tb_corner_smoother.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/corner_pkg.sv
// Shared definitions for the corner smoother: FSM states, screen limits,
// coordinate indices and the signed span helper.
package corner_pkg;

    localparam int unsigned COORD_W    = 10;
    localparam int unsigned SPAN_W     = 11;
    localparam int unsigned NUM_COORDS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned LOST_W     = 4;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned MAX_X    = SCREEN_W - 1;
    localparam int unsigned MAX_Y    = SCREEN_H - 1;

    // Coordinate order used for capture, shadow and output arrays
    localparam int unsigned IDX_TL_X = 0;
    localparam int unsigned IDX_TL_Y = 1;
    localparam int unsigned IDX_TR_X = 2;
    localparam int unsigned IDX_TR_Y = 3;
    localparam int unsigned IDX_BL_X = 4;
    localparam int unsigned IDX_BL_Y = 5;
    localparam int unsigned IDX_BR_X = 6;
    localparam int unsigned IDX_BR_Y = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        LOAD    = 3'd2,
        FILTER  = 3'd3,
        PUBLISH = 3'd4
    } state_e;

    // Signed edge length hi - lo; negative when the corners are swapped
    function automatic logic signed [SPAN_W-1:0] span(
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        span = $signed({1'b0, hi}) - $signed({1'b0, lo});
    endfunction

endpackage

// File: rtl/corner_smoother_if.sv
// Corner smoother bus: frame sync and raw corners in, smoothed corners and
// track status out.
//   master : upstream/testbench side (drives VGA_VS and raw corners)
//   slave  : corner_smoother side
interface corner_smoother_if;

    logic       VGA_VS;
    logic [9:0] tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y;
    logic [9:0] out_tl_x, out_tl_y, out_tr_x, out_tr_y;
    logic [9:0] out_bl_x, out_bl_y, out_br_x, out_br_y;
    logic       quad_valid;
    logic       update_pulse;
    logic       busy;
    logic [3:0] lost_count;

    modport master (
        output VGA_VS, tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y,
        input  out_tl_x, out_tl_y, out_tr_x, out_tr_y,
               out_bl_x, out_bl_y, out_br_x, out_br_y,
               quad_valid, update_pulse, busy, lost_count
    );

    modport slave (
        input  VGA_VS, tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y,
        output out_tl_x, out_tl_y, out_tr_x, out_tr_y,
               out_bl_x, out_bl_y, out_br_x, out_br_y,
               quad_valid, update_pulse, busy, lost_count
    );

endinterface

// File: rtl/corner_iir_step.sv
// One IIR step for a single coordinate: cur + ((cap - cur) >>> ALPHA_SHIFT),
// clamped to the screen. Optional deadband (CORNER_SMOOTH_DEADBAND_EN) holds
// the coordinate when |cap - cur| <= DEADBAND.
//   cap    : captured raw coordinate
//   cur    : currently published coordinate
//   is_y   : selects the y clamp limit
//   next_c : filtered coordinate (combinational)
module corner_iir_step
    import corner_pkg::*;
#(
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned DEADBAND    = 2
) (
    input  logic [COORD_W-1:0] cap,
    input  logic [COORD_W-1:0] cur,
    input  logic               is_y,
    output logic [COORD_W-1:0] next_c
);

`ifdef CORNER_SMOOTH_DEADBAND_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    localparam logic [SPAN_W-1:0] DB_LIM = SPAN_W'(DEADBAND);

    logic signed [SPAN_W-1:0]  diff;
    logic signed [SPAN_W-1:0]  step;
    logic        [SPAN_W-1:0]  mag;
    logic signed [SPAN_W:0]    sum;
    logic        [COORD_W-1:0] lim;
    logic                      hold;

    always_comb begin
        diff = $signed({1'b0, cap}) - $signed({1'b0, cur});
        step = diff >>> ALPHA_SHIFT;
        mag  = diff[SPAN_W-1] ? SPAN_W'(-diff) : SPAN_W'(diff);
        hold = DB_EN && (mag <= DB_LIM);
        // 12-bit sum: cur (<=639) plus a step of up to ~1023 must not wrap
        sum  = $signed({2'b00, cur}) + $signed({step[SPAN_W-1], step});
        lim  = is_y ? COORD_W'(MAX_Y) : COORD_W'(MAX_X);

        if (hold) begin
            next_c = cur;
        end else if (sum < 0) begin
            next_c = '0;
        end else if (sum > $signed({2'b00, lim})) begin
            next_c = lim;
        end else begin
            next_c = sum[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/corner_smoother.sv
// Temporal smoother for the four corners of a tracked quad. On each falling
// edge of VGA_VS the raw corners are captured and checked; a good quad is
// either loaded directly (first acquisition) or IIR-filtered one coordinate
// per cycle, then all eight outputs are published together. Bad quads count
// towards track loss. Optional deadband: CORNER_SMOOTH_DEADBAND_EN.
//   clk, reset : clock, synchronous active-high reset
//   bus        : corner_smoother_if.slave (VGA_VS, raw corners, smoothed
//                corners, quad_valid, update_pulse, busy, lost_count)
module corner_smoother
    import corner_pkg::*;
#(
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned MIN_SPAN    = 16,
    parameter int unsigned LOST_FRAMES = 8,
    parameter int unsigned DEADBAND    = 2
) (
    input  logic             clk,
    input  logic             reset,
    corner_smoother_if.slave bus
);

    localparam logic signed [SPAN_W-1:0] MIN_SPAN_S = SPAN_W'(MIN_SPAN);
    localparam logic [LOST_W-1:0]        LOST_MAX   = LOST_W'(LOST_FRAMES);
    localparam logic [IDX_W-1:0]         IDX_LAST   = IDX_W'(NUM_COORDS - 1);

    state_e state, state_nx;

    logic                vs_q;
    logic                vs_fall;
    logic [COORD_W-1:0]  raw   [NUM_COORDS];
    logic [COORD_W-1:0]  cap_r [NUM_COORDS];
    logic [COORD_W-1:0]  sh_r  [NUM_COORDS];
    logic [COORD_W-1:0]  out_r [NUM_COORDS];
    logic [IDX_W-1:0]    idx_r;
    logic                quad_valid_r;
    logic                update_pulse_r;
    logic [LOST_W-1:0]   lost_r;
    logic [LOST_W-1:0]   lost_nx;
    logic                quad_good;
    logic [COORD_W-1:0]  step_c;

    logic cap_en, good_en, bad_en, load_en, filt_en, pub_en;

    // Raw corner gather into index order
    always_comb begin
        raw[IDX_TL_X] = bus.tl_x;
        raw[IDX_TL_Y] = bus.tl_y;
        raw[IDX_TR_X] = bus.tr_x;
        raw[IDX_TR_Y] = bus.tr_y;
        raw[IDX_BL_X] = bus.bl_x;
        raw[IDX_BL_Y] = bus.bl_y;
        raw[IDX_BR_X] = bus.br_x;
        raw[IDX_BR_Y] = bus.br_y;
    end

    assign vs_fall = vs_q & ~bus.VGA_VS;

    // All four edges must be at least MIN_SPAN long; swapped corners fail
    always_comb begin
        quad_good = (span(cap_r[IDX_TL_X], cap_r[IDX_TR_X]) >= MIN_SPAN_S) &&
                    (span(cap_r[IDX_BL_X], cap_r[IDX_BR_X]) >= MIN_SPAN_S) &&
                    (span(cap_r[IDX_TL_Y], cap_r[IDX_BL_Y]) >= MIN_SPAN_S) &&
                    (span(cap_r[IDX_TR_Y], cap_r[IDX_BR_Y]) >= MIN_SPAN_S);
    end

    assign lost_nx = (lost_r == LOST_MAX) ? lost_r : lost_r + LOST_W'(1);

    // Single time-shared arithmetic step, indexed by the FILTER counter
    corner_iir_step #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .DEADBAND    (DEADBAND)
    ) u_step (
        .cap    (cap_r[idx_r]),
        .cur    (out_r[idx_r]),
        .is_y   (idx_r[0]),
        .next_c (step_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; VS edges outside IDLE are simply not looked at
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (vs_fall) state_nx = CHECK;
            CHECK:   begin
                if (!quad_good)        state_nx = IDLE;
                else if (quad_valid_r) state_nx = FILTER;
                else                   state_nx = LOAD;
            end
            LOAD:    state_nx = PUBLISH;
            FILTER:  if (idx_r == IDX_LAST) state_nx = PUBLISH;
            PUBLISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath enables decoded from state
    always_comb begin
        cap_en  = 1'b0;
        good_en = 1'b0;
        bad_en  = 1'b0;
        load_en = 1'b0;
        filt_en = 1'b0;
        pub_en  = 1'b0;
        case (state)
            IDLE:    cap_en  = vs_fall;
            CHECK:   begin
                good_en = quad_good;
                bad_en  = ~quad_good;
            end
            LOAD:    load_en = 1'b1;
            FILTER:  filt_en = 1'b1;
            PUBLISH: pub_en  = 1'b1;
            default: ;
        endcase
    end

    // Capture, shadow, output and track-status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q           <= 1'b0;
            idx_r          <= '0;
            quad_valid_r   <= 1'b0;
            update_pulse_r <= 1'b0;
            lost_r         <= '0;
            for (int i = 0; i < NUM_COORDS; i++) begin
                cap_r[i] <= '0;
                sh_r[i]  <= '0;
                out_r[i] <= '0;
            end
        end else begin
            vs_q           <= bus.VGA_VS;
            update_pulse_r <= pub_en;

            if (cap_en) begin
                for (int i = 0; i < NUM_COORDS; i++) cap_r[i] <= raw[i];
            end

            if (good_en) begin
                lost_r <= '0;
                idx_r  <= '0;
            end

            if (bad_en) begin
                lost_r <= lost_nx;
                if (lost_nx == LOST_MAX) quad_valid_r <= 1'b0;
            end

            if (load_en) begin
                for (int i = 0; i < NUM_COORDS; i++) sh_r[i] <= cap_r[i];
            end

            if (filt_en) begin
                sh_r[idx_r] <= step_c;
                idx_r       <= idx_r + IDX_W'(1);
            end

            // Outputs move only here, all eight in the same cycle
            if (pub_en) begin
                for (int i = 0; i < NUM_COORDS; i++) out_r[i] <= sh_r[i];
                quad_valid_r <= 1'b1;
            end
        end
    end

    assign bus.out_tl_x     = out_r[IDX_TL_X];
    assign bus.out_tl_y     = out_r[IDX_TL_Y];
    assign bus.out_tr_x     = out_r[IDX_TR_X];
    assign bus.out_tr_y     = out_r[IDX_TR_Y];
    assign bus.out_bl_x     = out_r[IDX_BL_X];
    assign bus.out_bl_y     = out_r[IDX_BL_Y];
    assign bus.out_br_x     = out_r[IDX_BR_X];
    assign bus.out_br_y     = out_r[IDX_BR_Y];
    assign bus.quad_valid   = quad_valid_r;
    assign bus.update_pulse = update_pulse_r;
    assign bus.lost_count   = lost_r;
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_corner_smoother.sv
// Self-checking bench for corner_smoother (default parameters): a table of
// frames with hand-computed outputs, then hand-written sequences for a
// second VS edge mid-filter, reset mid-filter and the deadband cases.
module tb_corner_smoother;

    logic clk;
    logic reset;

    corner_smoother_if bus ();

    corner_smoother dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0][9:0] outs;
    assign outs = {bus.out_br_y, bus.out_br_x, bus.out_bl_y, bus.out_bl_x,
                   bus.out_tr_y, bus.out_tr_x, bus.out_tl_y, bus.out_tl_x};

    typedef struct packed {
        logic [7:0][9:0] c;
        logic [7:0][9:0] o;
        logic signed [7:0] lat;
        logic            qv;
        logic [3:0]      lost;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0][9:0] p8(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7);
        logic [7:0][9:0] r;
        r[0] = 10'(a0); r[1] = 10'(a1); r[2] = 10'(a2); r[3] = 10'(a3);
        r[4] = 10'(a4); r[5] = 10'(a5); r[6] = 10'(a6); r[7] = 10'(a7);
        return r;
    endfunction

    function automatic vec_t mkv(input logic [7:0][9:0] c, input logic [7:0][9:0] o,
                                 input int lat, input logic qv, input int lost);
        vec_t v;
        v.c    = c;
        v.o    = o;
        v.lat  = 8'(lat);
        v.qv   = qv;
        v.lost = 4'(lost);
        return v;
    endfunction

    task automatic set_raw(input logic [7:0][9:0] c);
        bus.tl_x = c[0]; bus.tl_y = c[1]; bus.tr_x = c[2]; bus.tr_y = c[3];
        bus.bl_x = c[4]; bus.bl_y = c[5]; bus.br_x = c[6]; bus.br_y = c[7];
    endtask

    // Present corners, make VS fall so edge E is the second posedge, then
    // watch 14 cycles. fall2 > 0 makes VS fall again at edge E+fall2.
    task automatic run_frame(input string tag, input logic [7:0][9:0] c, input int fall2,
                             output int first, output int npulse);
        set_raw(c);
        bus.VGA_VS = 1'b1;
        @(posedge clk); #1;
        bus.VGA_VS = 1'b0;
        @(posedge clk); #1;
        check({tag, " busy_after_E"}, int'(bus.busy), 1);
        first  = -1;
        npulse = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == fall2 - 1) bus.VGA_VS = 1'b1;
            if (k == fall2)     bus.VGA_VS = 1'b0;
            @(posedge clk); #1;
            if (bus.update_pulse) begin
                if (first < 0) first = k;
                npulse++;
            end
        end
        check({tag, " idle_at_end"}, int'(bus.busy), 0);
    endtask

    task automatic check_outs(input string tag, input logic [7:0][9:0] exp);
        for (int j = 0; j < 8; j++)
            check($sformatf("%s out[%0d]", tag, j), int'(outs[j]), int'(exp[j]));
    endtask

    initial begin
        int first, np;
        logic [7:0][9:0] c, base;

        // Order: tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y
        base = p8(100, 100, 300, 100, 100, 300, 300, 300);
        vecs[0] = mkv(base, base, 3, 1'b1, 0);
        vecs[1] = mkv(p8(140,100,300,100,100,300,300,300), p8(110,100,300,100,100,300,300,300), 10, 1'b1, 0);
        vecs[2] = mkv(p8(140,100,300,100,100,300,300,300), p8(117,100,300,100,100,300,300,300), 10, 1'b1, 0);
        vecs[3] = mkv(p8(117,108,280,100,100,303,300,296), p8(117,102,295,100,100,300,300,299), 10, 1'b1, 0);
        vecs[4] = mkv(p8(117,102,295,100,100,300,1000,1000), p8(117,102,295,100,100,300,475,474), 10, 1'b1, 0);
        vecs[5] = mkv(p8(117,102,295,100,100,300,1000,1000), p8(117,102,295,100,100,300,606,479), 10, 1'b1, 0);
        vecs[6] = mkv(p8(117,102,295,100,100,300,1000,1000), p8(117,102,295,100,100,300,639,479), 10, 1'b1, 0);
        for (int i = 0; i < 8; i++)
            vecs[7+i] = mkv(p8(117,102,122,100,100,300,1000,1000), p8(117,102,295,100,100,300,639,479),
                            -1, (i < 7) ? 1'b1 : 1'b0, i + 1);
        vecs[15] = mkv(p8(117,102,50,100,100,300,1000,1000), p8(117,102,295,100,100,300,639,479), -1, 1'b0, 8);
        vecs[16] = mkv(base, base, 3, 1'b1, 0);
        vecs[17] = mkv(p8(100,100,115,100,100,300,300,300), base, -1, 1'b1, 1);
        vecs[18] = mkv(p8(100,100,116,100,100,300,300,300), p8(100,100,254,100,100,300,300,300), 10, 1'b1, 0);

        reset      = 1'b1;
        bus.VGA_VS = 1'b0;
        set_raw('0);
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(bus.busy), 0);
        check("reset quad_valid", int'(bus.quad_valid), 0);
        check("reset lost_count", int'(bus.lost_count), 0);
        check("reset update_pulse", int'(bus.update_pulse), 0);
        check_outs("reset", '0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_frame(tag, vecs[i].c, 0, first, np);
            check({tag, " pulse_cycle"}, first, int'(vecs[i].lat));
            check({tag, " pulse_count"}, np, (vecs[i].lat < 0) ? 0 : 1);
            check_outs(tag, vecs[i].o);
            check({tag, " quad_valid"}, int'(bus.quad_valid), int'(vecs[i].qv));
            check({tag, " lost_count"}, int'(bus.lost_count), int'(vecs[i].lost));
        end

        // Second VS fall at E+5 while filtering: dropped, one publish at E+10
        run_frame("midedge", p8(140,100,254,100,100,300,300,300), 5, first, np);
        check("midedge pulse_cycle", first, 10);
        check("midedge pulse_count", np, 1);
        check_outs("midedge", p8(110,100,254,100,100,300,300,300));

        // Reset sampled at E+4, in the middle of FILTER
        c = p8(200,100,300,100,100,300,300,300);
        set_raw(c);
        bus.VGA_VS = 1'b1;
        @(posedge clk); #1;
        bus.VGA_VS = 1'b0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst busy_before", int'(bus.busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst busy", int'(bus.busy), 0);
        check("midrst quad_valid", int'(bus.quad_valid), 0);
        check("midrst lost_count", int'(bus.lost_count), 0);
        check("midrst update_pulse", int'(bus.update_pulse), 0);
        check_outs("midrst", '0);

        run_frame("reacq", c, 0, first, np);
        check("reacq pulse_cycle", first, 3);
        check_outs("reacq", c);

        // Deadband region: a 2-pixel move floors to 0 either way; 4 pixels moves 1
        run_frame("db202", p8(202,100,300,100,100,300,300,300), 0, first, np);
        check("db202 pulse_cycle", first, 10);
        check("db202 tl_x", int'(bus.out_tl_x), 200);
        run_frame("db196", p8(196,100,300,100,100,300,300,300), 0, first, np);
        check("db196 pulse_cycle", first, 10);
        check("db196 tl_x", int'(bus.out_tl_x), 199);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
